alu_slice_1b: RTL and testbench



---
 rtl/alu_slice_1b_pkg.sv | 30 +++
 rtl/alu_slice_1b_if.sv | 17 +
 rtl/alu_fa_1b.sv | 11 +
 rtl/alu_slice_1b.sv | 114 +++++++++++
 tb/tb_alu_slice_1b.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/alu_slice_1b_pkg.sv
// Shared constants for the 1-bit ALU slice: mode selects (M1:M0) and the
// function selects (C1:C0) used within each mode.
package alu_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_CMP   = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_ARITH = 2'b11;

  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_XOR = 2'b10;
  localparam logic [1:0] FN_NOT = 2'b11;

  localparam logic [1:0] FN_EQ = 2'b00;
  localparam logic [1:0] FN_GT = 2'b01;
  localparam logic [1:0] FN_LT = 2'b10;
  localparam logic [1:0] FN_NE = 2'b11;

  localparam logic [1:0] FN_PASS_A = 2'b00;
  localparam logic [1:0] FN_PASS_B = 2'b01;
  localparam logic [1:0] FN_SHIFT  = 2'b10;
  localparam logic [1:0] FN_ZERO   = 2'b11;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_INC = 2'b10;
  localparam logic [1:0] FN_DEC = 2'b11;

endpackage

// File: rtl/alu_slice_1b_if.sv
// Operand/control/result bundle of the 1-bit ALU slice; the driver of the
// operands uses master, the slice itself uses slave.
interface alu_slice_1b_if;
  logic en;
  logic M1;
  logic M0;
  logic A;
  logic B;
  logic Cin;
  logic C1;
  logic C0;
  logic F;
  logic Cout;

  modport master (output en, M1, M0, A, B, Cin, C1, C0, input F, Cout);
  modport slave  (input en, M1, M0, A, B, Cin, C1, C0, output F, Cout);
endinterface

// File: rtl/alu_fa_1b.sv
// Purely combinational 1-bit full adder shared by all arithmetic functions.
module alu_fa_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/alu_slice_1b.sv
// Registered 1-bit ALU slice: logic, compare, pass/shift and full-adder units
// feed a one-hot mode mux, followed by an enabled output register.
module alu_slice_1b
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_slice_1b_if.slave bus
);

  logic [1:0] mode;
  logic [1:0] fn;
  logic [3:0] mode_oh;
  logic       logic_f;
  logic       cmp_f;
  logic       shift_f;
  logic       shift_co;
  logic       fa_b;
  logic       fa_s;
  logic       fa_co;
  logic       f_d;
  logic       cout_d;
  logic       f_q;
  logic       cout_q;

  assign mode    = {bus.M1, bus.M0};
  assign fn      = {bus.C1, bus.C0};
  assign mode_oh = 4'b0001 << mode;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    logic_f = 1'b0;
    unique case (fn)
      FN_AND:  logic_f = bus.A & bus.B;
      FN_OR:   logic_f = bus.A | bus.B;
      FN_XOR:  logic_f = bus.A ^ bus.B;
      FN_NOT:  logic_f = ~bus.A;
      default: logic_f = 1'b0;
    endcase
  end

  always_comb begin
    cmp_f = 1'b0;
    unique case (fn)
      FN_EQ:   cmp_f = ~(bus.A ^ bus.B);
      FN_GT:   cmp_f = bus.A & ~bus.B;
      FN_LT:   cmp_f = ~bus.A & bus.B;
      FN_NE:   cmp_f = bus.A ^ bus.B;
      default: cmp_f = 1'b0;
    endcase
  end

  // Shift mode moves Cin in on F and pushes A out on Cout toward the next slice.
  always_comb begin
    shift_f  = 1'b0;
    shift_co = 1'b0;
    unique case (fn)
      FN_PASS_A: shift_f = bus.A;
      FN_PASS_B: shift_f = bus.B;
      FN_SHIFT: begin
        shift_f  = bus.Cin;
        shift_co = bus.A;
      end
      FN_ZERO:   shift_f = 1'b0;
      default:   shift_f = 1'b0;
    endcase
  end

  // Subtract is A + ~B + Cin; decrement adds the all-ones operand.
  always_comb begin
    fa_b = 1'b0;
    unique case (fn)
      FN_ADD:  fa_b = bus.B;
      FN_SUB:  fa_b = ~bus.B;
      FN_INC:  fa_b = 1'b0;
      FN_DEC:  fa_b = 1'b1;
      default: fa_b = 1'b0;
    endcase
  end

  alu_fa_1b u_fa (
    .a  (bus.A),
    .b  (fa_b),
    .ci (bus.Cin),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    f_d    = (mode_oh[MODE_LOGIC] & logic_f)
           | (mode_oh[MODE_CMP]   & cmp_f)
           | (mode_oh[MODE_SHIFT] & shift_f)
           | (mode_oh[MODE_ARITH] & fa_s);
    cout_d = (mode_oh[MODE_SHIFT] & shift_co)
           | (mode_oh[MODE_ARITH] & fa_co);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= 1'b0;
      cout_q <= 1'b0;
    end else if (bus.en) begin
      f_q    <= f_d;
      cout_q <= cout_d;
    end
  end

  assign bus.F    = f_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_alu_slice_1b.sv
// Self-checking bench for alu_slice_1b: directed steps plus random traffic
// compared against an arithmetic reference model.
module tb_alu_slice_1b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q = 2'b00; // {Cout, F} the slice should be holding

  alu_slice_1b_if bus ();

  alu_slice_1b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference result {Cout, F} computed straight from the operation table.
  function automatic logic [1:0] ref_next(input logic [1:0] m, input logic [1:0] c,
                                          input logic a, input logic b, input logic cin);
    int ia = int'(a);
    int ib = int'(b);
    int ic = int'(cin);
    int s;
    case (m)
      2'd0: case (c)
              2'd0: return {1'b0, a & b};
              2'd1: return {1'b0, a | b};
              2'd2: return {1'b0, a ^ b};
              default: return {1'b0, ~a};
            endcase
      2'd1: case (c)
              2'd0: return {1'b0, ia == ib};
              2'd1: return {1'b0, ia > ib};
              2'd2: return {1'b0, ia < ib};
              default: return {1'b0, ia != ib};
            endcase
      2'd2: case (c)
              2'd0: return {1'b0, a};
              2'd1: return {1'b0, b};
              2'd2: return {a, cin};
              default: return 2'b00;
            endcase
      default: begin
        case (c)
          2'd0: s = ia + ib + ic;
          2'd1: s = ia + (1 - ib) + ic;
          2'd2: s = ia + ic;
          default: s = ia + 1 + ic;
        endcase
        return s[1:0];
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [1:0] c,
                       input logic a, input logic b, input logic cin);
    bus.en  = e;
    bus.M1  = m[1];
    bus.M0  = m[0];
    bus.C1  = c[1];
    bus.C0  = c[0];
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
  endtask

  // One clock edge; model updates, then both outputs are compared 1ns later.
  task automatic step(input string tag);
    logic [1:0] nxt;
    nxt = ref_next({bus.M1, bus.M0}, {bus.C1, bus.C0}, bus.A, bus.B, bus.Cin);
    @(posedge clk);
    if (bus.en && !rst) exp_q = nxt;
    #1;
    check({tag, "_f"}, bus.F, exp_q[0]);
    check({tag, "_cout"}, bus.Cout, exp_q[1]);
  endtask

  task automatic expect_fc(input string tag, input logic f, input logic co);
    check({tag, "_f_const"}, bus.F, f);
    check({tag, "_cout_const"}, bus.Cout, co);
  endtask

  initial begin
    logic [1:0] add_tbl [8];
    logic [2:0] v;
    logic [1:0] ab;
    add_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    expect_fc("reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q = 2'b00;

    // Add sweep over A,B,Cin = 000..111
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      drive(1'b1, 2'b11, 2'b00, v[2], v[1], v[0]);
      step("add");
      expect_fc("add_tbl", add_tbl[i][0], add_tbl[i][1]);
    end

    drive(1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b1); step("sub"); expect_fc("sub", 1'b1, 1'b0);
    drive(1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1); step("inc"); expect_fc("inc", 1'b0, 1'b1);
    drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0); step("dec"); expect_fc("dec", 1'b1, 1'b0);

    // Every logic and compare function with all four A,B combinations
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) begin
          ab = k[1:0];
          drive(1'b1, m[1:0], c[1:0], ab[1], ab[0], 1'b1);
          step("logic_cmp");
        end
      end
    end
    drive(1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0); step("xor11"); expect_fc("xor11", 1'b0, 1'b0);
    drive(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0); step("gt10");  expect_fc("gt10", 1'b1, 1'b0);
    drive(1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0); step("lt10");  expect_fc("lt10", 1'b0, 1'b0);

    drive(1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0); step("shift1"); expect_fc("shift1", 1'b0, 1'b1);
    drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1); step("shift2"); expect_fc("shift2", 1'b1, 1'b0);

    // Enable hold: load F=1, then inputs that would give sum 0 with en low
    drive(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0); step("hold_load"); expect_fc("hold_load", 1'b1, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("hold");
      expect_fc("hold", 1'b1, 1'b0);
    end

    // Random traffic including random enable
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      step("rand");
    end

    // Reset mid-cycle discards state without a clock edge
    drive(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0); step("pre_rst"); expect_fc("pre_rst", 1'b1, 1'b0);
    #3 rst = 1'b1;
    exp_q = 2'b00;
    #1;
    expect_fc("async_rst", 1'b0, 1'b0);
    step("rst_held");
    expect_fc("rst_held", 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    expect_fc("rst_released", 1'b0, 1'b0);
    step("post_rst");
    expect_fc("post_rst", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
